mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of EX; consumes the EX_MEM bundle {ALUOut, MemWriteData} plus control.
- Owns the EX/MEM and MEM/WB pipeline registers and the data-memory bus handshake.
- Stalls the upstream pipeline while a load/store waits on the bus.
- Supplies the MEM_*/WB_* forwarding signals that EX consumes.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_access_fsm.sv | 74 +++++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS MEM stage: write-back select codes,
// access FSM encodings and the EX_MEM bundle field positions.
package mem_stage_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    localparam int EXM_ALU_MSB = 63;
    localparam int EXM_ALU_LSB = 32;
    localparam int EXM_WD_MSB  = 31;
    localparam int EXM_WD_LSB  = 0;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory bus handshake: access state, timeout counter, request,
// pipeline stall and bus-error pulse.
//
// state     | meaning
// ST_IDLE   | no bus request outstanding
// ST_ACCESS | DMemValid high, waiting for DMemReady or timeout
import mem_stage_pkg::*;

module mem_access_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_ready,
    output logic o_valid,
    output logic o_stall,
    output logic o_abort,
    output logic o_bus_err
);

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e r_state;
    mem_state_e w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_bus_err;
    logic       w_access;
    logic       w_timeout;

    assign w_access  = (r_state == ST_ACCESS);
    // A ready arriving on the last allowed cycle still counts as completion.
    assign w_timeout = w_access & ~i_ready & (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_err <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_start) begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_ACCESS: begin
                    if (i_ready || w_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_valid   = w_access;
    assign o_stall   = w_access & ~i_ready;
    assign o_abort   = w_timeout;
    assign o_bus_err = r_bus_err;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM and MEM/WB registers,
// misalignment check, write-back select and forwarding outputs.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] EX_MEM,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_RegWrite,
    input  logic [1:0]  EX_MemToReg,
    input  logic [4:0]  EX_WriteRegister,
    input  logic [31:0] EX_PC4,
    input  logic        DMemReady,
    input  logic [31:0] DMemReadData,
    output logic        DMemValid,
    output logic        DMemWrite,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWriteData,
    output logic        MEM_Stall,
    output logic        MEM_AddrExc,
    output logic        MEM_BusErr,
    output logic        MEM_RegWrite,
    output logic [4:0]  MEM_WriteRegister,
    output logic [31:0] MEM_RegWriteData,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteRegister,
    output logic [31:0] WB_RegWriteData
);

    logic [31:0] r_alu_out;
    logic [31:0] r_wdata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic [1:0]  r_mtr;
    logic [4:0]  r_wreg;
    logic [31:0] r_pc4;
    logic        r_addr_exc;

    logic        r_wb_reg_write;
    logic [4:0]  r_wb_wreg;
    logic [31:0] r_wb_data;

    logic [31:0] w_ex_alu;
    logic [31:0] w_ex_wd;
    logic        w_ex_mem_op;
    logic        w_misalign;
    logic        w_capture;
    logic        w_start;
    logic        w_valid;
    logic        w_stall;
    logic        w_abort;
    logic [31:0] w_wb_mux;

    assign w_ex_alu    = EX_MEM[EXM_ALU_MSB:EXM_ALU_LSB];
    assign w_ex_wd     = EX_MEM[EXM_WD_MSB:EXM_WD_LSB];
    assign w_ex_mem_op = EX_MemRead | EX_MemWrite;
    assign w_misalign  = w_ex_mem_op & (w_ex_alu[1:0] != 2'b00);
    assign w_capture   = ~w_stall;
    assign w_start     = w_capture & w_ex_mem_op & ~w_misalign;

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_ready  (DMemReady),
        .o_valid  (w_valid),
        .o_stall  (w_stall),
        .o_abort  (w_abort),
        .o_bus_err(MEM_BusErr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out   <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_mtr       <= MTR_ALU;
            r_wreg      <= '0;
            r_pc4       <= '0;
            r_addr_exc  <= 1'b0;
        end else begin
            r_addr_exc <= w_capture & w_misalign;
            if (w_capture) begin
                r_alu_out   <= w_ex_alu;
                r_wdata     <= w_ex_wd;
                r_mem_read  <= EX_MemRead & ~w_misalign;
                r_mem_write <= EX_MemWrite & ~w_misalign;
                r_reg_write <= EX_RegWrite & ~w_misalign;
                r_mtr       <= EX_MemToReg;
                r_wreg      <= EX_WriteRegister;
                r_pc4       <= EX_PC4;
            end else if (w_abort) begin
                // Aborted op must not be retired by the following non-stall cycle.
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_reg_write <= 1'b0;
            end
        end
    end

    always_comb begin
        w_wb_mux = r_alu_out;
        case (r_mtr)
            MTR_MEM: w_wb_mux = DMemReadData;
            MTR_PC4: w_wb_mux = r_pc4;
            default: w_wb_mux = r_alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_reg_write <= 1'b0;
            r_wb_wreg      <= '0;
            r_wb_data      <= '0;
        end else if (w_stall) begin
            r_wb_reg_write <= 1'b0;
        end else begin
            r_wb_reg_write <= r_reg_write & ~r_mem_write;
            r_wb_wreg      <= r_wreg;
            r_wb_data      <= w_wb_mux;
        end
    end

    assign DMemValid     = w_valid;
    assign DMemWrite     = r_mem_write;
    assign DMemAddr      = r_alu_out;
    assign DMemWriteData = r_wdata;
    assign MEM_Stall     = w_stall;
    assign MEM_AddrExc   = r_addr_exc;

    assign MEM_RegWrite      = r_reg_write & ~w_valid;
    assign MEM_WriteRegister = r_wreg;
    assign MEM_RegWriteData  = (r_mtr == MTR_PC4) ? r_pc4 : r_alu_out;

    assign WB_RegWrite      = r_wb_reg_write;
    assign WB_WriteRegister = r_wb_wreg;
    assign WB_RegWriteData  = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a short bus timeout; write-backs
// are checked against a scoreboard filled as each instruction is driven.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] EX_MEM;
    logic        EX_MemRead, EX_MemWrite, EX_RegWrite;
    logic [1:0]  EX_MemToReg;
    logic [4:0]  EX_WriteRegister;
    logic [31:0] EX_PC4;
    logic        DMemReady;
    logic [31:0] DMemReadData;
    logic        DMemValid, DMemWrite;
    logic [31:0] DMemAddr, DMemWriteData;
    logic        MEM_Stall, MEM_AddrExc, MEM_BusErr, MEM_RegWrite;
    logic [4:0]  MEM_WriteRegister;
    logic [31:0] MEM_RegWriteData;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteRegister;
    logic [31:0] WB_RegWriteData;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .EX_MEM(EX_MEM),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_RegWrite(EX_RegWrite),
        .EX_MemToReg(EX_MemToReg), .EX_WriteRegister(EX_WriteRegister), .EX_PC4(EX_PC4),
        .DMemReady(DMemReady), .DMemReadData(DMemReadData),
        .DMemValid(DMemValid), .DMemWrite(DMemWrite), .DMemAddr(DMemAddr),
        .DMemWriteData(DMemWriteData), .MEM_Stall(MEM_Stall), .MEM_AddrExc(MEM_AddrExc),
        .MEM_BusErr(MEM_BusErr), .MEM_RegWrite(MEM_RegWrite),
        .MEM_WriteRegister(MEM_WriteRegister), .MEM_RegWriteData(MEM_RegWriteData),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
        .WB_RegWriteData(WB_RegWriteData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb_q[$];
    int c_stall, c_valid, c_buserr, c_addrexc;
    logic [31:0] exp_addr, exp_wd;
    logic        exp_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (MEM_Stall)   c_stall++;
            if (MEM_BusErr)  c_buserr++;
            if (MEM_AddrExc) c_addrexc++;
            if (DMemValid) begin
                c_valid++;
                chk("bus_addr_stable", {32'd0, DMemAddr}, {32'd0, exp_addr});
                chk("bus_we_stable", {63'd0, DMemWrite}, {63'd0, exp_we});
                chk("bus_wd_stable", {32'd0, DMemWriteData}, {32'd0, exp_wd});
            end
            if (WB_RegWrite) begin
                if (sb_q.size() == 0) begin
                    chk("wb_unexpected", {27'd0, WB_WriteRegister, WB_RegWriteData}, 64'd0);
                end else begin
                    chk("wb_result", {27'd0, WB_WriteRegister, WB_RegWriteData},
                        {27'd0, sb_q.pop_front()});
                end
            end
        end
    end

    task automatic drive_bubble();
        EX_MEM = '0; EX_MemRead = 0; EX_MemWrite = 0; EX_RegWrite = 0;
        EX_MemToReg = 2'b00; EX_WriteRegister = '0; EX_PC4 = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {63'd0, DMemValid}, 64'd0);
        chk({tag, "_stall"}, {63'd0, MEM_Stall}, 64'd0);
        chk({tag, "_flags"}, {61'd0, MEM_AddrExc, MEM_BusErr, DMemWrite}, 64'd0);
        chk({tag, "_fwd"}, {26'd0, MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData}, 64'd0);
        chk({tag, "_wb"}, {26'd0, WB_RegWrite, WB_WriteRegister, WB_RegWriteData}, 64'd0);
        chk({tag, "_bus"}, {DMemAddr, DMemWriteData}, 64'd0);
    endtask

    // Entered just after a rising edge; drives one op, then bubbles, for ncyc cycles.
    // dly: ACCESS cycle index in which DMemReady pulses (-1 = never).
    task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic rw, input logic [1:0] mtr,
                          input logic [31:0] pc4, input logic [31:0] rdata,
                          input int dly, input int ncyc);
        logic memop, mis, tmo;
        logic [31:0] d;
        memop = mr | mw;
        mis   = memop && (alu[1:0] != 2'b00);
        tmo   = memop && !mis && (dly < 0 || dly >= TMO);
        d     = (mtr == 2'b01) ? rdata : (mtr == 2'b10) ? pc4 : alu;
        if (rw && !mw && !mis && !tmo) sb_q.push_back({rd, d});
        exp_addr = alu; exp_wd = wd; exp_we = mw;
        c_stall = 0; c_valid = 0; c_buserr = 0; c_addrexc = 0;
        EX_MEM = {alu, wd}; EX_MemRead = mr; EX_MemWrite = mw; EX_RegWrite = rw;
        EX_MemToReg = mtr; EX_WriteRegister = rd; EX_PC4 = pc4; DMemReadData = rdata;
        @(posedge clk); #1;
        drive_bubble();
        DMemReady = (dly == 0);
        if (memop && !mis) begin
            chk("acc_valid", {63'd0, DMemValid}, 64'd1);
            chk("acc_fwd_off", {63'd0, MEM_RegWrite}, 64'd0);
        end else if (mis) begin
            chk("mis_valid", {63'd0, DMemValid}, 64'd0);
            chk("mis_exc", {63'd0, MEM_AddrExc}, 64'd1);
            chk("mis_fwd_off", {63'd0, MEM_RegWrite}, 64'd0);
        end else begin
            chk("fwd", {26'd0, MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData},
                {26'd0, rw, rd, (mtr == 2'b10) ? pc4 : alu});
        end
        for (int k = 1; k < ncyc; k++) begin
            @(posedge clk); #1;
            DMemReady = (k == dly);
        end
        @(posedge clk); #1;
        DMemReady = 0;
    endtask

    initial begin
        rst_n = 0; DMemReady = 0; DMemReadData = '0;
        exp_addr = '0; exp_wd = '0; exp_we = 0;
        drive_bubble();
        #23 rst_n = 1;
        @(posedge clk); #1;
        check_idle("reset");

        // ALU op
        run_op(32'h5, 32'h0, 5'd8, 0, 0, 1, 2'b00, 32'h0, 32'h0, -1, 3);
        chk("alu_stall", c_stall, 0);
        chk("alu_valid", c_valid, 0);

        // zero-wait load
        run_op(32'h100, 32'h0, 5'd9, 1, 0, 1, 2'b01, 32'h0, 32'hDEADBEEF, 0, 3);
        chk("ld0_valid", c_valid, 1);
        chk("ld0_stall", c_stall, 0);

        // store, ready three cycles late
        run_op(32'h20, 32'h1234, 5'd0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 3, 6);
        chk("st_valid", c_valid, 4);
        chk("st_stall", c_stall, 3);

        // misaligned load
        run_op(32'h102, 32'h0, 5'd10, 1, 0, 1, 2'b01, 32'h0, 32'h55, 0, 4);
        chk("mis_exc_cnt", c_addrexc, 1);
        chk("mis_valid_cnt", c_valid, 0);
        chk("mis_stall_cnt", c_stall, 0);

        // timeout abort
        run_op(32'h200, 32'h0, 5'd11, 1, 0, 1, 2'b01, 32'h0, 32'h66, -1, 7);
        chk("tmo_valid", c_valid, 4);
        chk("tmo_buserr", c_buserr, 1);
        chk("tmo_stall", c_stall, 4);

        // link write after the abort
        run_op(32'h77, 32'h0, 5'd31, 0, 0, 1, 2'b10, 32'h1004, 32'h0, -1, 3);
        chk("post_tmo_stall", c_stall, 0);

        // ready on the final allowed cycle wins over the timeout
        run_op(32'h300, 32'h0, 5'd12, 1, 0, 1, 2'b01, 32'h0, 32'hCAFEF00D, TMO - 1, 6);
        chk("late_rdy_valid", c_valid, 4);
        chk("late_rdy_stall", c_stall, 3);
        chk("late_rdy_buserr", c_buserr, 0);

        // MemToReg=11 selects ALUOut; $0 passes through
        run_op(32'hABCD, 32'h0, 5'd0, 0, 0, 1, 2'b11, 32'h999, 32'h0, -1, 3);

        // reset in the second ACCESS cycle
        exp_addr = 32'h40; exp_wd = 32'h0; exp_we = 0;
        EX_MEM = {32'h40, 32'h0}; EX_MemRead = 1; EX_RegWrite = 1;
        EX_MemToReg = 2'b01; EX_WriteRegister = 5'd13;
        @(posedge clk); #1;
        drive_bubble();
        @(posedge clk); #1;
        chk("pre_rst_valid", {63'd0, DMemValid}, 64'd1);
        chk("pre_rst_stall", {63'd0, MEM_Stall}, 64'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_valid", {63'd0, DMemValid}, 64'd0);
        chk("rst_stall", {63'd0, MEM_Stall}, 64'd0);
        chk("rst_regwr", {62'd0, MEM_RegWrite, WB_RegWrite}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        check_idle("post_rst");
        repeat (2) @(posedge clk);
        #1;
        check_idle("post_rst_hold");

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
